// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction memory port, execute redirect, and the decode handshake.
// The master modport is the sequencer; the slave modport is the surrounding pipeline.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  modport master (
`ifdef FETCH_PERF_EN
    output fetch_count,
`endif
    output imem_addr, out_valid, out_instr, out_pc, halted, fault,
    input  imem_data, redirect_valid, redirect_target, out_ready
  );

  modport slave (
`ifdef FETCH_PERF_EN
    input  fetch_count,
`endif
    input  imem_addr, out_valid, out_instr, out_pc, halted, fault,
    output imem_data, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer into a combinational big-endian imem, one-entry valid/ready slot to decode.
// Optional FETCH_PERF_EN adds a saturating fetch_count of words loaded into the slot.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 500
) (
  input  logic              Clk,
  input  logic              Rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {S_FETCH, S_HALT, S_FAULT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic        out_valid_q;
  logic        halted_q;
  logic        fault_q;
  logic        slot_free;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;
`endif

  // The memory itself returns zero past its end, so MEM_BYTES needs no logic here.
  logic unused_mem_bytes;
  assign unused_mem_bytes = (MEM_BYTES > 0);

  assign slot_free = !out_valid_q || bus.out_ready;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
`ifdef FETCH_PERF_EN
      fetch_count_q <= '0;
`endif
    end else begin
      case (state_q)
        S_FETCH, S_HALT: begin
          // A redirect wins over both fetch and acceptance; any pending word is dropped.
          if (bus.redirect_valid) begin
            out_valid_q <= 1'b0;
            pc_q        <= bus.redirect_target;
            if (bus.redirect_target[1:0] == 2'b00) begin
              state_q  <= S_FETCH;
              halted_q <= 1'b0;
            end else begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end else if (state_q == S_FETCH && slot_free) begin
            if (bus.imem_data != 32'h0) begin
              out_instr_q <= bus.imem_data;
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
              pc_q        <= pc_q + 32'd4;
`ifdef FETCH_PERF_EN
              if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_q <= fetch_count_q + 32'd1;
`endif
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= S_HALT;
              halted_q    <= 1'b1;
            end
          end else if (state_q == S_HALT && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;
`ifdef FETCH_PERF_EN
  assign bus.fetch_count = fetch_count_q;
`endif
endmodule
